key_pulse_gen: RTL and testbench

Upstream conditioning stage for the single-input Moore/Mealy state-machine labs. It takes a raw, bouncing, active-low DE-board pushbutton and produces a clean one-cycle advance pulse `x_pulse`. That pulse drives the `x` input of the downstream state machine, so one physical press advances it exactly one state. It also provides a debounced level and a press counter for LEDs/HEX display.

---
 rtl/key_pulse_gen.sv | 161 ++++++++++++++++
 tb/tb_key_pulse_gen.sv | 132 +++++++++++++
 2 files changed

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: synchronizes and debounces an active-low pushbutton into a one-cycle advance pulse.
// Optional auto-repeat while held is compiled in with `define KEY_AUTOREPEAT_EN.
module key_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  output logic       x_pulse,
  output logic       pressed,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit               DB_ONE  = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_s;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             rpt_fire;

  // Preset to released so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
    end
  end

  assign key_s = ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_s) begin
          if (DB_ONE) begin
            state_d = HELD;
            cnt_d   = '0;
            accept  = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else if (cnt_q < DB_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q < DB_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = $clog2(RPT_MAX + 1);

  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

  logic [RPT_W-1:0] rpt_q;
  logic             first_q;
  logic             stay_held;

  // Timer only runs across edges that begin and end in HELD.
  assign stay_held = (state_q == HELD) && (state_d == HELD);

  assign rpt_fire = stay_held &&
    (first_q ? (rpt_q == RPT_FIRST) : (rpt_q == RPT_NEXT));

  always_ff @(posedge clk) begin
    if (reset || !stay_held) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else if (rpt_fire) begin
      rpt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_q + RPT_ONE;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      x_pulse   <= 1'b0;
      pressed   <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      x_pulse <= accept | rpt_fire;
      pressed <= (state_d == HELD) || (state_d == RELEASE_WAIT);
      if (accept) begin
        press_cnt <= press_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Table-driven bench for key_pulse_gen (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Each vector: reset/key_n for one edge, then expected registered outputs.
module tb_key_pulse_gen;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic       x_pulse;
  logic       pressed;
  logic [7:0] press_cnt;

  key_pulse_gen #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .x_pulse  (x_pulse),
    .pressed  (pressed),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       kn;
    logic       x;
    logic       p;
    logic [7:0] c;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] ecnt = 8'd0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic add(input logic rst, input logic kn,
                     input logic x, input logic p, input logic inc);
    vec_t v;
    if (rst) ecnt = 8'd0;
    if (inc) ecnt = ecnt + 8'd1;
    v.rst = rst;
    v.kn  = kn;
    v.x   = x;
    v.p   = p;
    v.c   = ecnt;
    tbl.push_back(v);
  endtask

  task automatic add_reset(input int n);
    for (int k = 0; k < n; k++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Clean press: pulse after edge 6, pressed falls 6 edges after release.
  task automatic add_press(input int n_low, input int n_high);
    logic acc;
    logic rep;
    for (int k = 0; k < n_low + n_high; k++) begin
      acc = (k == 6);
      rep = AR && (k >= 16) && ((k - 16) % 5 == 0) && (k <= n_low + 1);
      add(1'b0, logic'(k >= n_low), acc | rep,
          logic'((k >= 6) && (k < n_low + 6)), acc);
    end
  endtask

  // Press bounce at edge 3, then release bounce at edges 16-17.
  task automatic add_bounce();
    logic kn;
    for (int k = 0; k < 36; k++) begin
      kn = (k == 3) || (k == 16) || (k == 17) || (k >= 24);
      add(1'b0, kn, logic'(k == 10),
          logic'((k >= 10) && (k < 30)), logic'(k == 10));
    end
  endtask

  // Reset asserted mid-debounce (edges 4-5), key held throughout.
  task automatic add_mid_reset();
    logic r;
    for (int k = 0; k < 26; k++) begin
      r = (k == 4) || (k == 5);
      add(r, logic'(k >= 16), logic'(k == 12),
          logic'((k >= 12) && (k < 22)), logic'(k == 12));
    end
  endtask

  task automatic check(input string name, input int i,
                       input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, i, act, exp);
    end
  endtask

  initial begin
    add_reset(3);
    add_press(20, 10);
    add_press(38, 10);
    add_reset(2);
    add_bounce();
    add_reset(2);
    add_mid_reset();
    add_reset(2);
    for (int n = 0; n < 256; n++) add_press(8, 8);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      key_n = tbl[i].kn;
      @(posedge clk);
      #1;
      check("x_pulse", i, {7'd0, x_pulse}, {7'd0, tbl[i].x});
      check("pressed", i, {7'd0, pressed}, {7'd0, tbl[i].p});
      check("press_cnt", i, press_cnt, tbl[i].c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
